// File: rtl/bounce_generator.sv
`default_nettype none
// ============================================================================
// Module   : bounce_generator
// Purpose  : Turns a clean level into a contact-bounce-like waveform using a
//            free-running Galois LFSR, then settles at the new level.
// Revision : 1.0 - initial release
// ============================================================================

module bounce_generator #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          MIN_BOUNCES = 4,
    parameter int          BOUNCE_BITS = 4,
    parameter int          GAP_BITS    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic clean_in,
    output logic bouncy_out,
    output logic busy
);

    // An all-zero seed would lock the LFSR, so it falls back to the default.
    localparam logic [15:0] c_seed  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] c_taps  = 16'hB400;
    localparam int          c_cnt_w = $clog2(MIN_BOUNCES + 2**BOUNCE_BITS);
    localparam int          c_gap_w = GAP_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_target;
    logic [c_cnt_w-1:0]   r_bounces_left;
    logic [c_gap_w-1:0]   r_gap;
    logic [15:0]          r_lfsr;

    state_t               w_state_next;
    logic                 w_target_next;
    logic [c_cnt_w-1:0]   w_bounces_next;
    logic [c_gap_w-1:0]   w_gap_next;
    logic                 w_out_next;
    logic                 w_busy_next;
    logic [15:0]          w_lfsr_next;
    logic [c_cnt_w-1:0]   w_load_bounces;
    logic [c_gap_w-1:0]   w_load_gap;
    logic [c_cnt_w-1:0]   w_bounces_dec;
    logic                 w_restart;

    // All rules read the pre-shift LFSR value; the shift itself never pauses.
    assign w_lfsr_next    = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_taps : 16'h0000);
    assign w_load_bounces = c_cnt_w'(MIN_BOUNCES) + c_cnt_w'(r_lfsr[BOUNCE_BITS-1:0]);
    assign w_load_gap     = c_gap_w'(r_lfsr[GAP_BITS-1:0]) + c_gap_w'(1);
    assign w_bounces_dec  = r_bounces_left - c_cnt_w'(1);
    assign w_restart      = (clean_in != r_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_target       <= 1'b0;
            r_bounces_left <= '0;
            r_gap          <= '0;
            r_lfsr         <= c_seed;
            bouncy_out     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_target       <= w_target_next;
            r_bounces_left <= w_bounces_next;
            r_gap          <= w_gap_next;
            r_lfsr         <= w_lfsr_next;
            bouncy_out     <= w_out_next;
            busy           <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_target_next  = r_target;
        w_bounces_next = r_bounces_left;
        w_gap_next     = r_gap;
        w_out_next     = bouncy_out;
        w_busy_next    = busy;

        if (!ena) begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
            w_out_next   = clean_in;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clean_in != bouncy_out) begin
                        w_target_next  = clean_in;
                        w_bounces_next = w_load_bounces;
                        w_gap_next     = w_load_gap;
                        w_busy_next    = 1'b1;
                        w_state_next   = S_BOUNCE;
                    end
                end
                S_BOUNCE: begin
                    // A new clean edge restarts the burst ahead of any gap action.
                    if (w_restart) begin
                        w_target_next  = clean_in;
                        w_bounces_next = w_load_bounces;
                        w_gap_next     = w_load_gap;
                        w_state_next   = S_BOUNCE;
                    end else if (r_gap == c_gap_w'(1)) begin
                        w_out_next     = r_lfsr[15];
                        w_bounces_next = w_bounces_dec;
                        if (w_bounces_dec == '0) begin
                            w_state_next = S_SETTLE;
                        end else begin
                            w_gap_next = w_load_gap;
                        end
                    end else begin
                        w_gap_next = r_gap - c_gap_w'(1);
                    end
                end
                S_SETTLE: begin
                    if (w_restart) begin
                        w_target_next  = clean_in;
                        w_bounces_next = w_load_bounces;
                        w_gap_next     = w_load_gap;
                        w_state_next   = S_BOUNCE;
                    end else begin
                        w_out_next   = r_target;
                        w_busy_next  = 1'b0;
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounce_generator
// Purpose  : Randomized bench for bounce_generator against a burst-schedule model
//            plus a loopback debouncer check on two seeds.
// Revision : 1.0 - initial release
// ============================================================================

module tb_bounce_generator;

    localparam logic [15:0] c_seed0    = 16'hACE1;
    localparam int          c_min_b    = 4;
    localparam int          c_t_max    = 154;
    localparam int          c_deb_tick = 200;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ena      = 1'b0;
    logic clean_in = 1'b0;
    logic bouncy_out, busy;
    logic bouncy1, busy1;

    int vectors    = 0;
    int miscompares = 0;

    bounce_generator #(.SEED(c_seed0)) dut (
        .clk(clk), .rst(rst), .ena(ena), .clean_in(clean_in),
        .bouncy_out(bouncy_out), .busy(busy)
    );

    bounce_generator #(.SEED(16'h0001)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .clean_in(clean_in),
        .bouncy_out(bouncy1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Reference model: on each burst start, the whole event schedule is
    // precomputed from the free-running LFSR sequence.
    logic [15:0] m_lfsr   = c_seed0;
    logic        exp_out  = 1'b0;
    logic        exp_busy = 1'b0;
    logic        m_target = 1'b0;
    int          m_t      = 0;
    int          settle_t = -1;
    int          ev_t[$];
    bit          ev_v[$];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] r = v;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    task automatic model_step();
        logic [15:0] v;
        int te, g, n;
        if (rst) begin
            m_lfsr = c_seed0; exp_out = 1'b0; exp_busy = 1'b0; m_target = 1'b0;
            m_t = 0; settle_t = -1; ev_t.delete(); ev_v.delete();
            return;
        end
        if (!ena) begin
            exp_out = clean_in; exp_busy = 1'b0;
            ev_t.delete(); ev_v.delete(); settle_t = -1;
        end else if ((!exp_busy && clean_in != exp_out) || (exp_busy && clean_in != m_target)) begin
            m_target = clean_in; exp_busy = 1'b1;
            ev_t.delete(); ev_v.delete();
            n = c_min_b + int'(m_lfsr[3:0]);
            g = int'(m_lfsr[2:0]) + 1;
            v = m_lfsr; te = m_t;
            for (int k = 0; k < n; k++) begin
                te += g;
                v = lfsr_adv(v, g);
                ev_t.push_back(te);
                ev_v.push_back(v[15]);
                g = int'(v[2:0]) + 1;
            end
            settle_t = te + 1;
        end else if (exp_busy) begin
            if (ev_t.size() > 0 && ev_t[0] == m_t) begin
                exp_out = ev_v[0];
                void'(ev_t.pop_front());
                void'(ev_v.pop_front());
            end else if (m_t == settle_t) begin
                exp_out = m_target; exp_busy = 1'b0;
            end
        end
        m_lfsr = lfsr_step(m_lfsr);
        m_t++;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    task automatic test_reset;
        rst = 1'b1; ena = 1'b0; clean_in = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bouncy_out !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: out=%b busy=%b, expected 0/0", bouncy_out, busy);
        end
        vectors++;
        if (dut.r_lfsr !== 16'hACE1) begin
            miscompares++;
            $display("FAIL reset_lfsr: lfsr=%h, expected ace1", dut.r_lfsr);
        end
        rst = 1'b0; ena = 1'b1; clean_in = 1'b1;
        repeat (12) begin
            @(negedge clk);
            vectors++;
            if (bouncy_out !== exp_out || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL pre_reset_burst: out=%b busy=%b, expected %b/%b at %0t",
                         bouncy_out, busy, exp_out, exp_busy, $time);
            end
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (bouncy_out !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: out=%b busy=%b, expected 0/0", bouncy_out, busy);
        end
        clean_in = 1'b0;
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (dut.r_lfsr !== 16'hACE1) begin
            miscompares++;
            $display("FAIL release_lfsr: lfsr=%h, expected ace1", dut.r_lfsr);
        end
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (bouncy_out !== exp_out || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL post_reset: out=%b busy=%b, expected %b/%b", bouncy_out, busy, exp_out, exp_busy);
            end
        end
    endtask

    task automatic test_bypass;
        logic [5:0] seq = 6'b010011;
        ena = 1'b0;
        for (int i = 0; i < 6; i++) begin
            clean_in = seq[i];
            @(negedge clk);
            vectors++;
            if (bouncy_out !== seq[i] || busy !== 1'b0 || bouncy_out !== exp_out) begin
                miscompares++;
                $display("FAIL bypass: out=%b busy=%b, expected %b/0", bouncy_out, busy, seq[i]);
            end
        end
    endtask

    task automatic test_burst(input logic level);
        int first_busy = -1, fall_cyc = -1, last_change = 0;
        logic prev;
        ena = 1'b1; clean_in = level; prev = bouncy_out;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            vectors++;
            if (bouncy_out !== exp_out || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL burst_%b: out=%b busy=%b, expected %b/%b at cycle %0d",
                         level, bouncy_out, busy, exp_out, exp_busy, c);
            end
            if (busy === 1'b1 && first_busy < 0) first_busy = c;
            if (busy === 1'b0 && first_busy >= 0 && fall_cyc < 0) fall_cyc = c;
            if (bouncy_out !== prev) last_change = c;
            prev = bouncy_out;
        end
        vectors++;
        if (first_busy != 1) begin
            miscompares++;
            $display("FAIL busy_rise_%b: first busy cycle %0d, expected 1", level, first_busy);
        end
        vectors++;
        if (fall_cyc < 0 || fall_cyc > c_t_max) begin
            miscompares++;
            $display("FAIL settle_bound_%b: busy fell at %0d, expected 1..%0d", level, fall_cyc, c_t_max);
        end
        vectors++;
        if (bouncy_out !== level || last_change > fall_cyc) begin
            miscompares++;
            $display("FAIL final_level_%b: out=%b last change %0d busy fall %0d, expected out=%b",
                     level, bouncy_out, last_change, fall_cyc, level);
        end
    endtask

    task automatic test_mid_burst;
        int last_high = 0;
        ena = 1'b1; clean_in = 1'b1;
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (bouncy_out !== exp_out || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL mid_rise: out=%b busy=%b, expected %b/%b", bouncy_out, busy, exp_out, exp_busy);
            end
        end
        clean_in = 1'b0;
        for (int c = 1; c <= 170; c++) begin
            @(negedge clk);
            vectors++;
            if (bouncy_out !== exp_out || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL mid_fall: out=%b busy=%b, expected %b/%b at cycle %0d",
                         bouncy_out, busy, exp_out, exp_busy, c);
            end
            if (bouncy_out === 1'b1 || busy === 1'b1) last_high = c;
        end
        vectors++;
        if (last_high > c_t_max || bouncy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_settle: out=%b last active cycle %0d, expected 0 within %0d",
                     bouncy_out, last_high, c_t_max);
        end
    endtask

    task automatic test_random;
        ena = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            vectors++;
            if (bouncy_out !== exp_out || busy !== exp_busy) begin
                miscompares++;
                $display("FAIL random: out=%b busy=%b, expected %b/%b at cycle %0d",
                         bouncy_out, busy, exp_out, exp_busy, c);
            end
            if (c < 840) begin
                if ($urandom_range(0, 11) == 0) clean_in = ~clean_in;
                if ($urandom_range(0, 79) == 0) ena = ~ena;
            end else begin
                ena = 1'b1;
            end
        end
    endtask

    task automatic test_loopback;
        logic d0, d1;
        int c0, c1, tr0, tr1, hold;
        rst = 1'b1; ena = 1'b1; clean_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0 = 1'b0; d1 = 1'b0; c0 = 0; c1 = 0;
        for (int e = 0; e < 10; e++) begin
            clean_in = ~clean_in;
            tr0 = 0; tr1 = 0;
            hold = 400 + int'($urandom_range(0, 40));
            repeat (hold) begin
                @(negedge clk);
                vectors++;
                if (bouncy_out !== exp_out || busy !== exp_busy) begin
                    miscompares++;
                    $display("FAIL loop_model: out=%b busy=%b, expected %b/%b", bouncy_out, busy, exp_out, exp_busy);
                end
                if (bouncy_out !== d0) begin
                    c0++;
                    if (c0 >= c_deb_tick) begin d0 = bouncy_out; c0 = 0; tr0++; end
                end else c0 = 0;
                if (bouncy1 !== d1) begin
                    c1++;
                    if (c1 >= c_deb_tick) begin d1 = bouncy1; c1 = 0; tr1++; end
                end else c1 = 0;
            end
            vectors++;
            if (tr0 != 1 || d0 !== clean_in) begin
                miscompares++;
                $display("FAIL loopback_seed_ace1: %0d transitions deb=%b, expected 1 and %b", tr0, d0, clean_in);
            end
            vectors++;
            if (tr1 != 1 || d1 !== clean_in) begin
                miscompares++;
                $display("FAIL loopback_seed_0001: %0d transitions deb=%b, expected 1 and %b", tr1, d1, clean_in);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_burst(1'b1);
        test_burst(1'b0);
        test_mid_burst();
        test_random();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
